// File: rtl/rsa_pkg.sv
// Shared encodings for the RSA sequencing blocks: exponentiation FSM states
// and the modular-multiply operation selector.
package rsa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        ISSUE,
        WAIT,
        DRAIN,
        NEXT,
        FIN
    } state_t;

    typedef enum logic [1:0] {
        LOAD,
        SQR,
        MUL
    } op_t;

endpackage

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing base^exp mod m through an external mod_mul.
// Latency: k+1 edges for exp=0, else per product ISSUE+WAIT+DRAIN+NEXT; start ignored while busy, mul_done waited on.
module mod_exp_ctrl
    import rsa_pkg::*;
#(
    parameter int k    = 12,
    parameter int logk = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [k-1:0]  base,
    input  logic [k-1:0]  exp,
    output logic [k-1:0]  result,
    output logic          done,
    output logic          busy,
    output logic [k-1:0]  mul_x,
    output logic [k-1:0]  mul_y,
    output logic          mul_start,
    input  logic [k-1:0]  mul_z,
    input  logic          mul_done
);

    localparam logic [logk-1:0] CNT_TOP = logk'(k - 1);
    localparam logic [k-1:0]    ONE     = k'(1);

    state_t          state_q, state_d;
    op_t             op_q, op_d;
    logic [k-1:0]    b_q, b_d;
    logic [k-1:0]    e_q, e_d;
    logic [k-1:0]    acc_q, acc_d;
    logic [logk-1:0] cnt_q, cnt_d;
    logic [k-1:0]    result_q, result_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            mul_start_q, mul_start_d;
    logic [k-1:0]    mul_x_q, mul_x_d;
    logic [k-1:0]    mul_y_q, mul_y_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= LOAD;
            b_q         <= '0;
            e_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            mul_start_q <= 1'b0;
            mul_x_q     <= '0;
            mul_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            b_q         <= b_d;
            e_q         <= e_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            mul_start_q <= mul_start_d;
            mul_x_q     <= mul_x_d;
            mul_y_q     <= mul_y_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        b_d         = b_q;
        e_d         = e_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        done_d      = done_q;
        busy_d      = busy_q;
        mul_start_d = mul_start_q;
        mul_x_d     = mul_x_q;
        mul_y_d     = mul_y_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    b_d     = base;
                    e_d     = exp;
                    cnt_d   = CNT_TOP;
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end
            // Skip leading zero exponent bits before the first LOAD.
            SCAN: begin
                if (e_q[cnt_q]) begin
                    op_d    = LOAD;
                    state_d = ISSUE;
                end else if (cnt_q == '0) begin
                    result_d = ONE;
                    done_d   = 1'b1;
                    state_d  = FIN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ISSUE: begin
                mul_start_d = 1'b1;
                case (op_q)
                    LOAD: begin
                        mul_x_d = b_q;
                        mul_y_d = ONE;
                    end
                    SQR: begin
                        mul_x_d = acc_q;
                        mul_y_d = acc_q;
                    end
                    default: begin
                        mul_x_d = acc_q;
                        mul_y_d = b_q;
                    end
                endcase
                state_d = WAIT;
            end
            WAIT: begin
                if (mul_done) begin
                    acc_d       = mul_z;
                    mul_start_d = 1'b0;
                    state_d     = DRAIN;
                end
            end
            // Level-style done must fall before the next request is issued.
            DRAIN: begin
                if (!mul_done) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (op_q == SQR && e_q[cnt_q]) begin
                    op_d    = MUL;
                    state_d = ISSUE;
                end else if (cnt_q == '0) begin
                    result_d = acc_q;
                    done_d   = 1'b1;
                    state_d  = FIN;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    op_d    = SQR;
                    state_d = ISSUE;
                end
            end
            FIN: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign result    = result_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign mul_start = mul_start_q;
    assign mul_x     = mul_x_q;
    assign mul_y     = mul_y_q;

endmodule
